// File: rtl/decode_hazard_controller.sv
// Decode-stage interlock: per-register countdown scoreboard plus
// stall / freeze / flush arbitration toward the ID/EX register.
module decode_hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WB_LATENCY     = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [1:0]                id_reg_file_ren,
  input  logic [REG_ADDR_WIDTH-1:0] id_src_a_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_src_b_addr,
  input  logic [1:0]                id_reg_file_wen,
  input  logic [REG_ADDR_WIDTH-1:0] id_dst_addr,
  input  logic                      id_mem_access,
  input  logic                      mem_busy,
  input  logic                      flush,
  input  logic                      stall_cnt_clr,
  output logic                      id_issue,
  output logic                      id_stall,
  output logic                      ex_bubble,
  output logic [1:0]                ctrl_state,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_FREEZE = 2'b10,
    ST_FLUSH  = 2'b11
  } state_e;

  logic [3:0]           cnt_q [NUM_REGS];
  logic [3:0]           cnt_d [NUM_REGS];
  logic                 flush_pend_q, flush_pend_d;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  logic frz, mem_hz, raw_a, raw_b, raw_hz, flush_eff;
  logic sel_frz, sel_fl, sel_raw, sel_run;

  always_comb begin
    frz       = mem_busy;
    mem_hz    = id_valid & id_mem_access & frz;
    raw_a     = id_reg_file_ren[0] & (cnt_q[id_src_a_addr] != 4'd0);
    raw_b     = id_reg_file_ren[1] & (cnt_q[id_src_b_addr] != 4'd0);
    raw_hz    = id_valid & (raw_a | raw_b);
    flush_eff = (flush | flush_pend_q) & ~frz;
    // One-hot row select; a memory hazard is always a freeze
    sel_frz   = frz | mem_hz;
    sel_fl    = flush_eff & ~sel_frz;
    sel_raw   = raw_hz & ~sel_frz & ~sel_fl;
    sel_run   = ~sel_frz & ~sel_fl & ~sel_raw;
  end

  always_comb begin
    id_issue  = 1'b0;
    id_stall  = 1'b0;
    ex_bubble = 1'b0;
    state_d   = ST_RUN;
    unique case (1'b1)
      sel_frz: begin
        id_stall = 1'b1;
        state_d  = ST_FREEZE;
      end
      sel_fl: begin
        ex_bubble = 1'b1;
        state_d   = ST_FLUSH;
      end
      sel_raw: begin
        id_stall  = 1'b1;
        ex_bubble = 1'b1;
        state_d   = ST_STALL;
      end
      sel_run: begin
        id_issue  = id_valid;
        ex_bubble = ~id_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!frz && cnt_q[i] != 4'd0)
        cnt_d[i] = cnt_q[i] - 4'd1;
    end
    if (id_issue && (|id_reg_file_wen))
      cnt_d[id_dst_addr] = 4'(WB_LATENCY);
  end

  always_comb begin
    flush_pend_d = frz ? (flush_pend_q | flush) : 1'b0;
    stall_d      = stall_q;
    if (stall_cnt_clr)
      stall_d = '0;
    else if (id_stall && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt_q[i] <= 4'd0;
      flush_pend_q <= 1'b0;
      state_q      <= ST_RUN;
      stall_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt_q[i] <= cnt_d[i];
      flush_pend_q <= flush_pend_d;
      state_q      <= state_d;
      stall_q      <= stall_d;
    end
  end

  assign ctrl_state   = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_decode_hazard_controller.sv
// Directed bench for decode_hazard_controller.
// Inputs change 1 ns after rising edges; outputs sampled on falling edges.
module tb_decode_hazard_controller;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [1:0] id_reg_file_ren;
  logic [4:0] id_src_a_addr;
  logic [4:0] id_src_b_addr;
  logic [1:0] id_reg_file_wen;
  logic [4:0] id_dst_addr;
  logic       id_mem_access;
  logic       mem_busy;
  logic       flush;
  logic       stall_cnt_clr;
  logic       id_issue;
  logic       id_stall;
  logic       ex_bubble;
  logic [1:0] ctrl_state;
  logic [3:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  decode_hazard_controller #(
    .REG_ADDR_WIDTH(5),
    .WB_LATENCY(3),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_reg_file_ren(id_reg_file_ren),
    .id_src_a_addr(id_src_a_addr),
    .id_src_b_addr(id_src_b_addr),
    .id_reg_file_wen(id_reg_file_wen),
    .id_dst_addr(id_dst_addr),
    .id_mem_access(id_mem_access),
    .mem_busy(mem_busy),
    .flush(flush),
    .stall_cnt_clr(stall_cnt_clr),
    .id_issue(id_issue),
    .id_stall(id_stall),
    .ex_bubble(ex_bubble),
    .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] ren,
                     input logic [4:0] a, input logic [4:0] b,
                     input logic [1:0] wen, input logic [4:0] dst,
                     input logic busy, input logic fl);
    id_valid        = v;
    id_reg_file_ren = ren;
    id_src_a_addr   = a;
    id_src_b_addr   = b;
    id_reg_file_wen = wen;
    id_dst_addr     = dst;
    id_mem_access   = busy;
    mem_busy        = busy;
    flush           = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic ctl(input string tag, input logic iss,
                     input logic stl, input logic bub);
    chk({tag, ".issue"}, 32'(id_issue), 32'(iss));
    chk({tag, ".stall"}, 32'(id_stall), 32'(stl));
    chk({tag, ".bubble"}, 32'(ex_bubble), 32'(bub));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    stall_cnt_clr = 1'b0;
    drv(1, 2'b11, 5'd1, 5'd2, 2'b00, 5'd0, 0, 0);
    #3;
    ctl("rst", 1, 0, 0);
    chk("rst.cnt", 32'(stall_cycles), 0);
    chk("rst.state", 32'(ctrl_state), 0);
    tick();
    rst_n = 1'b1;

    // RAW on r5 via source A
    drv(1, 2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 0, 0);
    samp();
    ctl("raw.c0", 1, 0, 0);
    tick();
    drv(1, 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 0, 0);
    samp();
    ctl("raw.c1", 0, 1, 1);
    tick();
    samp();
    ctl("raw.c2", 0, 1, 1);
    chk("raw.c2.state", 32'(ctrl_state), 1);
    tick();
    samp();
    ctl("raw.c3", 0, 1, 1);
    chk("raw.c3.state", 32'(ctrl_state), 1);
    tick();
    samp();
    ctl("raw.c4", 1, 0, 0);
    chk("raw.c4.state", 32'(ctrl_state), 1);
    chk("raw.c4.cnt", 32'(stall_cycles), 3);
    tick();
    samp();
    chk("raw.c5.state", 32'(ctrl_state), 0);

    // Independent sources; then source B and unread-source cases
    tick();
    do_reset();
    drv(1, 2'b00, 5'd0, 5'd0, 2'b10, 5'd5, 0, 0);
    samp();
    ctl("nohz.c0", 1, 0, 0);
    tick();
    drv(1, 2'b11, 5'd6, 5'd7, 2'b00, 5'd0, 0, 0);
    samp();
    ctl("nohz.c1", 1, 0, 0);
    tick();
    drv(1, 2'b10, 5'd0, 5'd5, 2'b00, 5'd0, 0, 0);
    samp();
    ctl("srcb.c2", 0, 1, 1);
    tick();
    drv(1, 2'b00, 5'd5, 5'd5, 2'b00, 5'd0, 0, 0);
    samp();
    ctl("noren.c3", 1, 0, 0);
    tick();
    drv(1, 2'b01, 5'd9, 5'd0, 2'b01, 5'd9, 0, 0);
    samp();
    ctl("self.c4", 1, 0, 0);
    tick();
    drv(1, 2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 0, 0);
    samp();
    ctl("self.c5", 0, 1, 1);
    tick();
    drv(0, 2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 0, 0);
    samp();
    ctl("idle.c6", 0, 0, 1);

    // Freeze stretches the RAW window
    tick();
    do_reset();
    drv(1, 2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 0, 0);
    tick();
    drv(1, 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 1, 0);
    samp();
    ctl("frz.c1", 0, 1, 0);
    tick();
    tick();
    tick();
    samp();
    ctl("frz.c4", 0, 1, 0);
    tick();
    drv(1, 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 0, 0);
    samp();
    ctl("frz.c5", 0, 1, 1);
    chk("frz.c5.state", 32'(ctrl_state), 2);
    tick();
    tick();
    samp();
    ctl("frz.c7", 0, 1, 1);
    tick();
    samp();
    ctl("frz.c8", 1, 0, 0);
    chk("frz.c8.cnt", 32'(stall_cycles), 7);

    // Flush deferred across a freeze, applied once
    tick();
    do_reset();
    drv(1, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0);
    tick();
    drv(1, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1, 0);
    tick();
    drv(1, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1, 1);
    samp();
    ctl("dfl.c2", 0, 1, 0);
    tick();
    tick();
    drv(1, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 0, 0);
    samp();
    ctl("dfl.c4", 0, 0, 1);
    chk("dfl.c4.state", 32'(ctrl_state), 2);
    tick();
    samp();
    ctl("dfl.c5", 1, 0, 0);
    chk("dfl.c5.state", 32'(ctrl_state), 3);
    tick();
    drv(1, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 0, 1);
    samp();
    ctl("fl.c6", 0, 0, 1);

    // Reset mid-freeze drops hazards and the deferred flush
    tick();
    do_reset();
    drv(1, 2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 0, 0);
    tick();
    drv(1, 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 1, 1);
    samp();
    ctl("mrst.c1", 0, 1, 0);
    tick();
    do_reset();
    drv(1, 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 0, 0);
    samp();
    ctl("mrst.c2", 1, 0, 0);
    chk("mrst.c2.state", 32'(ctrl_state), 0);

    // Saturation and clear with a 4-bit counter
    tick();
    do_reset();
    drv(1, 2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 0, 0);
    tick();
    drv(1, 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 1, 0);
    repeat (10) tick();
    samp();
    chk("sat.c11.cnt", 32'(stall_cycles), 10);
    repeat (10) tick();
    samp();
    chk("sat.c21.cnt", 32'(stall_cycles), 15);
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    samp();
    chk("sat.clr.cnt", 32'(stall_cycles), 0);
    chk("sat.clr.stall", 32'(id_stall), 1);
    tick();
    samp();
    chk("sat.inc.cnt", 32'(stall_cycles), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_hazard_controller.md
# decode_hazard_controller

Pipeline interlock controller for the decode stage. Tracks in-flight register-file writes in a per-register countdown scoreboard. Decides each cycle whether the instruction in decode may issue, must stall (data or memory hazard), or must be killed (flush). Sits between the decode logic outputs and the ID/EX pipeline register, driving the decode stall, PC hold and EX bubble-insert controls.

## Interface

Parameters:
- REG_ADDR_WIDTH, 5: width of register addresses; NUM_REGS = 2**REG_ADDR_WIDTH.
- WB_LATENCY, 3: cycles from issue to register-file write-back commit; legal range 1..15.
- CNT_WIDTH, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_reg_file_ren  in  2  bit0 = source A is read, bit1 = source B is read.
- id_src_a_addr  in  REG_ADDR_WIDTH  source A register.
- id_src_b_addr  in  REG_ADDR_WIDTH  source B register.
- id_reg_file_wen  in  2  any bit set = instruction writes id_dst_addr.
- id_dst_addr  in  REG_ADDR_WIDTH  destination register.
- id_mem_access  in  1  OR of main memory, frame buffer and call stack enables.
- mem_busy  in  1  memory stage has an access outstanding; the pipeline freezes.
- flush  in  1  single-cycle redirect pulse from execute; kills the decode instruction.
- stall_cnt_clr  in  1  synchronous clear of stall_cycles.
- id_issue  out  1  decode instruction advances into EX this cycle.
- id_stall  out  1  hold the IF/ID register and PC.
- ex_bubble  out  1  load a NOP into ID/EX.
- ctrl_state  out  2  registered classification of the previous cycle.
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with id_stall=1.

## Operation

- Scoreboard: one counter per register, width 4, all reset to 0.
- Hazard terms, all combinational from current inputs and current counter values:
  - raw_hz = id_valid & ((ren[0] & cnt[src_a]!=0) | (ren[1] & cnt[src_b]!=0)).
  - frz = mem_busy.
  - mem_hz = id_valid & id_mem_access & frz.
- flush_eff = (flush | flush_pend) & !frz.
- flush_pend is a 1-bit register:
  - set when flush=1 and frz=1;
  - cleared on the first cycle with frz=0, which applies the deferred flush.
- Output priority, one row applies per cycle:
  - frz: id_stall=1, id_issue=0, ex_bubble=0. Nothing advances.
  - flush_eff: id_issue=0, ex_bubble=1, id_stall=0.
  - raw_hz: id_stall=1, ex_bubble=1, id_issue=0.
  - else: id_issue=id_valid, ex_bubble=!id_valid, id_stall=0.
- Counter update at each edge:
  - When frz=1, all counters hold.
  - Otherwise every nonzero counter decrements by 1.
  - When id_issue=1 and id_reg_file_wen!=0, cnt[id_dst_addr] loads WB_LATENCY. This overrides the decrement, including the WAW case where the counter is already nonzero.
- Hazard checks always use the pre-update counter values. An instruction whose source equals its own destination does not self-stall.
- No register is special-cased; register 0 is tracked like any other.
- ctrl_state, registered at each edge from the current cycle's row: RUN=00 (issue or idle), STALL=01 (raw_hz), FREEZE=10 (frz), FLUSH=11 (flush_eff).
- stall_cycles:
  - increments when id_stall=1;
  - saturates at all-ones;
  - stall_cnt_clr sets it to 0 and takes priority over the increment.

## Timing

- Reset (rst_n=0, asynchronous): all counters 0, flush_pend=0, ctrl_state=00, stall_cycles=0.
- While in reset, combinational outputs follow the Operation rows with counters at 0.
- id_issue, id_stall and ex_bubble are combinational, valid in the same cycle as their inputs.
- ctrl_state lags them by one cycle.
- Back-to-back dependency: an instruction issuing in cycle N that writes r causes a reader of r to stall in cycles N+1..N+WB_LATENCY and issue in cycle N+WB_LATENCY+1.
- Freeze cycles extend this window one-for-one, because counters hold during freeze.
- A flush during freeze takes effect on the first non-busy cycle, exactly once, even if flush was asserted across several busy cycles.
- Reset asserted mid-stall or mid-freeze clears all pending hazards and any deferred flush immediately.

## Test plan

- Reset: rst_n=0 with id_valid=1 and ren=11 -> id_issue=1, stall_cycles=0, ctrl_state=00. After release, all counters are 0.
- RAW, default parameters:
  - Stimulus: issue in cycle 0 writing r5; in cycle 1 an instruction reading r5 on source A.
  - Required: id_stall=1 and ex_bubble=1 in cycles 1-3; id_issue=1 in cycle 4; stall_cycles=3; ctrl_state=01 in cycles 2-4.
- No hazard: writer of r5, then reader of r6 and r7 -> issues in cycle 1, no stall.
- Freeze:
  - Stimulus: writer of r5 in cycle 0; mem_busy=1 in cycles 1-4; reader of r5 from cycle 1.
  - Required: stall in cycles 1-7 with ex_bubble=0 in 1-4; issue in cycle 8; stall_cycles=7.
- Deferred flush: flush=1 in cycle 2 while mem_busy=1 in cycles 1-3 -> flush applies in cycle 4 only (ex_bubble=1, id_issue=0); ctrl_state=11 in cycle 5.
- Saturation and clear:
  - Stimulus: CNT_WIDTH=4, hold a RAW hazard by continuous freeze for 20 cycles.
  - Required: stall_cycles=15 and holds; stall_cnt_clr=1 -> 0 next cycle.
